// File: rtl/coherence_sequencer_pkg.sv
// Shared types for the two-core coherence sequencer: interconnect message
// codes, directory entry layout, request op codes and FSM state encoding.
package coherence_sequencer_pkg;

    localparam int MSG_W = 3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [MSG_W-1:0] {
        MSG_NONE       = 3'b000,
        MSG_INVALIDATE = 3'b001,
        MSG_DOWNGRADE  = 3'b010
    } msg_e;

    typedef enum logic [1:0] {
        DIR_I = 2'b00,
        DIR_S = 2'b01,
        DIR_M = 2'b10
    } dirState_e;

    // In DIR_M exactly one sharer bit is set and it names the owner.
    typedef struct packed {
        dirState_e  state;
        logic [1:0] sharers;
    } dirEntry_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_LOOKUP = 3'b001,
        ST_SNOOP  = 3'b010,
        ST_MEM    = 3'b011,
        ST_RESP   = 3'b100
    } fsmState_e;

    // Directory entry after a completed request from cache 'self'.
    function automatic dirEntry_t dirUpdate(input dirEntry_t cur, input logic op, input logic self);
        dirEntry_t  nxt;
        logic [1:0] selfMask;
        selfMask = self ? 2'b10 : 2'b01;
        if (op == OP_WRITE) begin
            nxt.state   = DIR_M;
            nxt.sharers = selfMask;
        end else if ((cur.state == DIR_M) && (cur.sharers == selfMask)) begin
            nxt = cur;
        end else begin
            nxt.state   = DIR_S;
            nxt.sharers = cur.sharers | selfMask;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/coherence_sequencer_if.sv
// Bundle of core-side request/response/snoop signals and the shared-memory
// port. 'slave' is the sequencer's view, 'master' is the environment's view
// (both L1 caches plus the memory).
interface coherence_sequencer_if
    import coherence_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0, req1;
    logic              op0, op1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [MSG_W-1:0]  msg_to0, msg_to1;
    logic              ack0, ack1;
    logic              mem_valid;
    logic              mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, ack0, ack1,
               mem_rdata, mem_ready,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, msg_to0, msg_to1,
               mem_valid, mem_op, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, ack0, ack1,
               mem_rdata, mem_ready,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, msg_to0, msg_to1,
               mem_valid, mem_op, mem_addr, mem_wdata
    );

endinterface

// File: rtl/coherence_sequencer_rr_arbiter2.sv
// Two-way round-robin pick. A lone requester wins; on a tie the cache that
// did not win last time gets the grant.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic lastWinner,
    output logic valid,
    output logic winner
);

    // Combinational winner selection.
    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            winner = ~lastWinner;
        end else begin
            winner = req1;
        end
    end

endmodule

// File: rtl/coherence_sequencer.sv
// Directory controller and arbiter for two L1 caches. Grants one request at a
// time, snoops the peer cache when the full-map MSI directory requires it,
// then performs one shared-memory access and pulses done.
module coherence_sequencer
    import coherence_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    coherence_sequencer_if.slave bus
);

    localparam int DIR_DEPTH = 1 << ADDR_W;

    fsmState_e         state_r;
    logic              lastWinner_r;
    logic              winner_r;
    logic              op_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              gnt0_r, gnt1_r;
    logic              done0_r, done1_r;
    logic [DATA_W-1:0] rdata0_r, rdata1_r;
    msg_e              msgTo0_r, msgTo1_r;
    logic              memValid_r;

    dirEntry_t         directory_r [DIR_DEPTH];
    dirEntry_t         lookupEntry_s;
    dirEntry_t         nextEntry_s;
    msg_e              snoopMsg_s;
    logic              peer_s;
    logic              peerAck_s;
    logic              arbValid_s;
    logic              arbWinner_s;

    rr_arbiter2 uArb (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .lastWinner (lastWinner_r),
        .valid      (arbValid_s),
        .winner     (arbWinner_s)
    );

    // Directory read for the latched address and the snoop decision.
    always_comb begin
        peer_s        = ~winner_r;
        lookupEntry_s = directory_r[addr_r];
        nextEntry_s   = dirUpdate(lookupEntry_s, op_r, winner_r);
        if ((op_r == OP_WRITE) && lookupEntry_s.sharers[peer_s]) begin
            snoopMsg_s = MSG_INVALIDATE;
        end else if ((op_r == OP_READ) && (lookupEntry_s.state == DIR_M)
                     && lookupEntry_s.sharers[peer_s]) begin
            snoopMsg_s = MSG_DOWNGRADE;
        end else begin
            snoopMsg_s = MSG_NONE;
        end
    end

    // Only the snooped (peer) cache's acknowledge counts.
    always_comb begin
        if (winner_r) begin
            peerAck_s = bus.ack0;
        end else begin
            peerAck_s = bus.ack1;
        end
    end

    // Directory flop array; written once per request on its response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIR_DEPTH; i++) begin
                directory_r[i] <= '{state: DIR_I, sharers: 2'b00};
            end
        end else if (state_r == ST_RESP) begin
            directory_r[addr_r] <= nextEntry_s;
        end
    end

    // Sequencer FSM with registered grant, done, message and memory outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            lastWinner_r <= 1'b1;
            winner_r     <= 1'b0;
            op_r         <= OP_READ;
            addr_r       <= '0;
            wdata_r      <= '0;
            gnt0_r       <= 1'b0;
            gnt1_r       <= 1'b0;
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
            rdata0_r     <= '0;
            rdata1_r     <= '0;
            msgTo0_r     <= MSG_NONE;
            msgTo1_r     <= MSG_NONE;
            memValid_r   <= 1'b0;
        end else begin
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            done0_r <= 1'b0;
            done1_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (arbValid_s) begin
                        winner_r <= arbWinner_s;
                        op_r     <= arbWinner_s ? bus.op1 : bus.op0;
                        addr_r   <= arbWinner_s ? bus.addr1 : bus.addr0;
                        wdata_r  <= arbWinner_s ? bus.wdata1 : bus.wdata0;
                        gnt0_r   <= ~arbWinner_s;
                        gnt1_r   <= arbWinner_s;
                        state_r  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (snoopMsg_s != MSG_NONE) begin
                        if (winner_r) begin
                            msgTo0_r <= snoopMsg_s;
                        end else begin
                            msgTo1_r <= snoopMsg_s;
                        end
                        state_r <= ST_SNOOP;
                    end else begin
                        memValid_r <= 1'b1;
                        state_r    <= ST_MEM;
                    end
                end
                ST_SNOOP: begin
                    // Waits indefinitely; a stale sharer bit still needs its ack.
                    if (peerAck_s) begin
                        msgTo0_r   <= MSG_NONE;
                        msgTo1_r   <= MSG_NONE;
                        memValid_r <= 1'b1;
                        state_r    <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    if (bus.mem_ready) begin
                        memValid_r <= 1'b0;
                        if (op_r == OP_READ) begin
                            if (winner_r) begin
                                rdata1_r <= bus.mem_rdata;
                            end else begin
                                rdata0_r <= bus.mem_rdata;
                            end
                        end
                        done0_r <= ~winner_r;
                        done1_r <= winner_r;
                        state_r <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    lastWinner_r <= winner_r;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    msgTo0_r   <= MSG_NONE;
                    msgTo1_r   <= MSG_NONE;
                    memValid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt0      = gnt0_r;
    assign bus.gnt1      = gnt1_r;
    assign bus.done0     = done0_r;
    assign bus.done1     = done1_r;
    assign bus.rdata0    = rdata0_r;
    assign bus.rdata1    = rdata1_r;
    assign bus.msg_to0   = msgTo0_r;
    assign bus.msg_to1   = msgTo1_r;
    assign bus.mem_valid = memValid_r;
    assign bus.mem_op    = op_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;

endmodule

// File: tb/tb_coherence_sequencer.sv
// Directed bench for coherence_sequencer: a table of single transactions whose
// snoop messages follow from hand-tracked directory state, plus hand-written
// sequences for arbitration ties and reset during a snoop.
module tb_coherence_sequencer;

    localparam logic [2:0] M_NONE = 3'b000;
    localparam logic [2:0] M_INV  = 3'b001;
    localparam logic [2:0] M_DNG  = 3'b010;

    typedef struct {
        logic       port;
        logic       op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] memData;
        logic [2:0] expMsg;
        int         ackDelay;
        int         readyDelay;
    } vec_t;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    int   cyc;
    vec_t vecs [16];

    coherence_sequencer_if bus ();

    coherence_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic port, input logic op, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] memData,
                                input logic [2:0] expMsg, input int ackDelay, input int readyDelay);
        vec_t v;
        v.port = port; v.op = op; v.addr = addr; v.wdata = wdata; v.memData = memData;
        v.expMsg = expMsg; v.ackDelay = ackDelay; v.readyDelay = readyDelay;
        return v;
    endfunction

    function automatic logic [2:0] msgTo(input logic port);
        return port ? bus.msg_to1 : bus.msg_to0;
    endfunction

    function automatic logic doneOf(input logic port);
        return port ? bus.done1 : bus.done0;
    endfunction

    function automatic logic [7:0] rdataOf(input logic port);
        return port ? bus.rdata1 : bus.rdata0;
    endfunction

    task automatic setReq(input logic port, input logic val, input logic op,
                          input logic [7:0] addr, input logic [7:0] wdata);
        if (port) begin
            bus.req1 = val; bus.op1 = op; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = val; bus.op0 = op; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    task automatic setAck(input logic port, input logic val);
        if (port) bus.ack1 = val;
        else      bus.ack0 = val;
    endtask

    task automatic waitGnt(input logic port);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) got = 1'b1;
        end
        check("gnt_seen", got, 1);
        check("gnt_port", port ? bus.gnt1 : bus.gnt0, 1);
        check("gnt_other", port ? bus.gnt0 : bus.gnt1, 0);
    endtask

    // One complete request from v.port, servicing snoop and memory.
    task automatic runTxn(input vec_t v);
        int   t0;
        int   expLat;
        logic peer;
        logic stable;
        peer = ~v.port;
        @(negedge clk);
        setReq(v.port, 1'b1, v.op, v.addr, v.wdata);
        t0 = cyc;
        waitGnt(v.port);
        @(negedge clk);
        check("msg_peer", msgTo(peer), v.expMsg);
        check("msg_self", msgTo(v.port), M_NONE);
        if (v.expMsg != M_NONE) begin
            check("snoop_no_mem", bus.mem_valid, 0);
            stable = 1'b1;
            for (int k = 0; k < v.ackDelay; k++) begin
                setAck(v.port, k == 0);
                @(negedge clk);
                if (msgTo(peer) !== v.expMsg || bus.mem_valid !== 1'b0) stable = 1'b0;
            end
            setAck(v.port, 1'b0);
            setAck(peer, 1'b1);
            @(negedge clk);
            setAck(peer, 1'b0);
            check("msg_held", stable, 1);
            check("msg_cleared", msgTo(peer), M_NONE);
        end
        check("mem_valid", bus.mem_valid, 1);
        check("mem_op", bus.mem_op, v.op);
        check("mem_addr", bus.mem_addr, v.addr);
        if (v.op) check("mem_wdata", bus.mem_wdata, v.wdata);
        stable = 1'b1;
        for (int k = 0; k < v.readyDelay; k++) begin
            @(negedge clk);
            if (bus.mem_valid !== 1'b1 || bus.mem_op !== v.op || bus.mem_addr !== v.addr) stable = 1'b0;
        end
        check("mem_held", stable, 1);
        bus.mem_rdata = v.memData;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        expLat = 3 + v.readyDelay + ((v.expMsg != M_NONE) ? (v.ackDelay + 1) : 0);
        check("done", doneOf(v.port), 1);
        check("done_other", doneOf(peer), 0);
        check("latency", cyc - t0, expLat);
        check("mem_drop", bus.mem_valid, 0);
        if (!v.op) check("rdata", rdataOf(v.port), v.memData);
        setReq(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        check("done_pulse", doneOf(v.port), 0);
    endtask

    // Memory phase of a non-snooping request already granted.
    task automatic serviceMem(input logic port, input logic [7:0] data);
        @(negedge clk);
        check("tie_mem_valid", bus.mem_valid, 1);
        bus.mem_rdata = data;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        check("tie_done", doneOf(port), 1);
        check("tie_done_other", doneOf(~port), 0);
        check("tie_rdata", rdataOf(port), data);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.op0 = 1'b0; bus.op1 = 1'b0;
        bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
        bus.ack0 = 1'b0; bus.ack1 = 1'b0; bus.mem_rdata = 8'h00; bus.mem_ready = 1'b0;

        // Directory state after each row is noted as (state, sharers C1C0).
        vecs[0]  = mk(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, M_NONE, 0, 0); // S 01
        vecs[1]  = mk(1'b1, 1'b1, 8'h10, 8'h3C, 8'h00, M_INV,  0, 0); // M 10
        vecs[2]  = mk(1'b0, 1'b0, 8'h10, 8'h00, 8'h3C, M_DNG,  2, 0); // S 11
        vecs[3]  = mk(1'b0, 1'b1, 8'h10, 8'h77, 8'h00, M_INV,  1, 0); // M 01
        vecs[4]  = mk(1'b0, 1'b0, 8'h10, 8'h00, 8'h77, M_NONE, 0, 0); // M 01
        vecs[5]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 8'h77, M_DNG,  0, 1); // S 11
        vecs[6]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 8'h77, M_NONE, 0, 0); // S 11
        vecs[7]  = mk(1'b0, 1'b0, 8'h20, 8'h00, 8'h11, M_NONE, 0, 0); // S 01
        vecs[8]  = mk(1'b1, 1'b1, 8'h20, 8'h22, 8'h00, M_INV,  3, 0); // M 10
        vecs[9]  = mk(1'b1, 1'b1, 8'h30, 8'h99, 8'h00, M_NONE, 0, 0); // M 10
        vecs[10] = mk(1'b0, 1'b0, 8'h30, 8'h00, 8'h99, M_DNG,  4, 0); // S 11
        vecs[11] = mk(1'b1, 1'b1, 8'h30, 8'h5A, 8'h00, M_INV,  0, 5); // M 10
        vecs[12] = mk(1'b1, 1'b1, 8'h30, 8'h5B, 8'h00, M_NONE, 0, 0); // M 10
        vecs[13] = mk(1'b0, 1'b0, 8'h40, 8'h00, 8'hC3, M_NONE, 0, 5); // S 01
        vecs[14] = mk(1'b1, 1'b0, 8'h40, 8'h00, 8'hC4, M_NONE, 0, 0); // S 11
        vecs[15] = mk(1'b0, 1'b1, 8'h40, 8'hE1, 8'h00, M_INV,  0, 0); // M 01

        #12;
        check("rst_gnt", {bus.gnt0, bus.gnt1}, 0);
        check("rst_done", {bus.done0, bus.done1}, 0);
        check("rst_msg", {bus.msg_to0, bus.msg_to1}, 0);
        check("rst_mem_valid", bus.mem_valid, 0);
        check("rst_rdata", {bus.rdata0, bus.rdata1}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Tie straight out of reset: C0 first; C0 re-requesting meets C1 -> C1.
        @(negedge clk);
        setReq(1'b0, 1'b1, 1'b0, 8'h60, 8'h00);
        setReq(1'b1, 1'b1, 1'b0, 8'h61, 8'h00);
        waitGnt(1'b0);
        serviceMem(1'b0, 8'h01);
        waitGnt(1'b1);
        serviceMem(1'b1, 8'h02);
        setReq(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        waitGnt(1'b0);
        serviceMem(1'b0, 8'h03);
        setReq(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        // Fresh tie after C0 won last: C1 first.
        @(negedge clk);
        @(negedge clk);
        setReq(1'b0, 1'b1, 1'b0, 8'h60, 8'h00);
        setReq(1'b1, 1'b1, 1'b0, 8'h61, 8'h00);
        waitGnt(1'b1);
        serviceMem(1'b1, 8'h04);
        setReq(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        waitGnt(1'b0);
        serviceMem(1'b0, 8'h05);
        setReq(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            runTxn(vecs[i]);
        end

        // Reset while C1 is being asked to downgrade 0x70.
        runTxn(mk(1'b1, 1'b1, 8'h70, 8'h01, 8'h00, M_NONE, 0, 0));
        @(negedge clk);
        setReq(1'b0, 1'b1, 1'b0, 8'h70, 8'h00);
        waitGnt(1'b0);
        @(negedge clk);
        check("snoop_before_rst", bus.msg_to1, M_DNG);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_msg", {bus.msg_to0, bus.msg_to1}, 0);
        check("rst_mid_mem", bus.mem_valid, 0);
        check("rst_mid_flags", {bus.gnt0, bus.gnt1, bus.done0, bus.done1}, 0);
        @(negedge clk);
        setReq(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_msg", {bus.msg_to0, bus.msg_to1}, 0);
        check("post_rst_idle", {bus.gnt0, bus.gnt1, bus.mem_valid}, 0);
        // Directory cleared: no snoops for previously shared/owned lines.
        runTxn(mk(1'b0, 1'b0, 8'h70, 8'h00, 8'h42, M_NONE, 0, 0));
        runTxn(mk(1'b1, 1'b1, 8'h10, 8'h43, 8'h00, M_NONE, 0, 0));
        runTxn(mk(1'b1, 1'b1, 8'h40, 8'h44, 8'h00, M_NONE, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
